// File: rtl/r_mux_s4_if.sv
// ---------------------------------------------------------------------------
// r_mux_s4_if: R-channel bundle for the 4-slave read-data return mux.
//  s_axi_*   : four slave R channels, packed slave k at [k*W +: W]
//  m00_axi_* : the single merged master R channel
//  r_grant   : one-hot current burst owner (0 when idle)
// Modports:
//  master : the mux side; drives m00_axi_* R payload/valid, s_axi_rready, r_grant
//  slave  : the environment side; drives s_axi_* payload/valid and m00_axi_rready
// ---------------------------------------------------------------------------
interface r_mux_s4_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic [4*DATA_W-1:0] s_axi_rdata;
    logic [4*ID_W-1:0]   s_axi_rid;
    logic [7:0]          s_axi_rresp;
    logic [3:0]          s_axi_rlast;
    logic [3:0]          s_axi_rvalid;
    logic [3:0]          s_axi_rready;

    logic [DATA_W-1:0]   m00_axi_rdata;
    logic [ID_W-1:0]     m00_axi_rid;
    logic [1:0]          m00_axi_rresp;
    logic                m00_axi_rlast;
    logic                m00_axi_rvalid;
    logic                m00_axi_rready;

    logic [3:0]          r_grant;

    modport master (
        input  s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  m00_axi_rready,
        output s_axi_rready,
        output m00_axi_rdata, m00_axi_rid, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
        output r_grant
    );

    modport slave (
        output s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output m00_axi_rready,
        input  s_axi_rready,
        input  m00_axi_rdata, m00_axi_rid, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
        input  r_grant
    );
endinterface

// File: rtl/r_mux_s4.sv
// ---------------------------------------------------------------------------
// r_mux_s4: read-data return path of the 4-slave read interconnect.
//  Merges four slave R channels onto one master R channel. A round-robin
//  arbiter locks onto one slave for a whole burst (until RLAST) and forwards
//  its beats through a single registered output stage (1 beat/clk).
// Ports:
//  clk    : clock, rising edge
//  reset  : synchronous, active-high; drops any in-flight beat
//  bus    : r_mux_s4_if.master (slave R channels in, master R channel out,
//           s_axi_rready combinational, r_grant registered one-hot owner)
// ---------------------------------------------------------------------------
module r_mux_s4 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned NUM_S  = 4
) (
    input  logic          clk,
    input  logic          reset,
    r_mux_s4_if.master    bus
);
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_S-1:0]    grant_q, grant_d;

    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;

    logic [DATA_W-1:0]   rdata_arr_c [NUM_S];
    logic [ID_W-1:0]     rid_arr_c   [NUM_S];
    logic [1:0]          rresp_arr_c [NUM_S];

    logic                out_free_c;
    logic                beat_fire_c;
    logic                pick_found_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic [IDX_W-1:0]    cand_c;

    // Unpack the flat slave buses into per-slave arrays
    always_comb begin
        for (int k = 0; k < NUM_S; k++) begin
            rdata_arr_c[k] = bus.s_axi_rdata[k*DATA_W +: DATA_W];
            rid_arr_c[k]   = bus.s_axi_rid[k*ID_W +: ID_W];
            rresp_arr_c[k] = bus.s_axi_rresp[k*2 +: 2];
        end
    end

    // Round-robin pick: first requester at rr_ptr, rr_ptr+1, ... (mod 4)
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = rr_ptr_q;
        cand_c       = '0;
        for (int i = 0; i < NUM_S; i++) begin
            cand_c = rr_ptr_q + IDX_W'(i);
            if (!pick_found_c && bus.s_axi_rvalid[cand_c]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // Output register may take a new beat when empty or being drained this cycle
    assign out_free_c  = ~rvalid_q | bus.m00_axi_rready;
    assign beat_fire_c = (state_q == BURST) & bus.s_axi_rvalid[gidx_q] & out_free_c;

    assign bus.s_axi_rready = (state_q == BURST && out_free_c) ? grant_q : '0;

    // Next-state: arbitration, burst tracking and output stage
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    state_d = BURST;
                    gidx_d  = pick_idx_c;
                    grant_d = NUM_S'(1) << pick_idx_c;
                end
            end
            BURST: begin
                // Last beat leaves the burst; it still drains from the output register
                if (beat_fire_c && bus.s_axi_rlast[gidx_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = gidx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat_fire_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rdata_arr_c[gidx_q];
            rid_d    = rid_arr_c[gidx_q];
            rresp_d  = rresp_arr_c[gidx_q];
            rlast_d  = bus.s_axi_rlast[gidx_q];
        end else if (rvalid_q && bus.m00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    assign bus.m00_axi_rvalid = rvalid_q;
    assign bus.m00_axi_rdata  = rdata_q;
    assign bus.m00_axi_rid    = rid_q;
    assign bus.m00_axi_rresp  = rresp_q;
    assign bus.m00_axi_rlast  = rlast_q;
    assign bus.r_grant        = grant_q;

endmodule

// File: tb/tb_r_mux_s4.sv
// ---------------------------------------------------------------------------
// tb_r_mux_s4: self-checking bench for r_mux_s4.
//  Slave models present queued beats; expected master beats are queued when
//  stimulus is issued and compared as the master accepts them. Directed
//  checks cover grant timing, bubble, round-robin, backpressure and reset.
// ---------------------------------------------------------------------------
module tb_r_mux_s4;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk;
    logic reset;

    r_mux_s4_if #(.DATA_W(32), .ID_W(4)) bus ();

    r_mux_s4 #(.DATA_W(32), .ID_W(4), .NUM_S(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sq [4][$];
    beat_t exp_q [$];
    logic [3:0] fired;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mkb(input logic [31:0] d, input logic [3:0] id,
                                  input logic [1:0] r, input logic l);
        beat_t b;
        b.data = d;
        b.id   = id;
        b.resp = r;
        b.last = l;
        return b;
    endfunction

    // Queue a beat at slave s; optionally expect it at the master
    task automatic send(input int s, input beat_t b, input bit expect_out);
        sq[s].push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < 4; k++) n += sq[k].size();
        return n;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0) && n < 300) begin
            step(1);
            n++;
        end
        chk(tag, 64'(exp_q.size() + pending()), 64'(0));
        step(2);
    endtask

    // Slave drivers and master-side scoreboard
    logic [127:0] drv_d;
    logic [15:0]  drv_id;
    logic [7:0]   drv_rs;
    logic [3:0]   drv_l;
    logic [3:0]   drv_v;
    beat_t        got_b;
    beat_t        exp_b;

    initial begin
        fired              = '0;
        bus.s_axi_rdata    = '0;
        bus.s_axi_rid      = '0;
        bus.s_axi_rresp    = '0;
        bus.s_axi_rlast    = '0;
        bus.s_axi_rvalid   = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (fired[k] && sq[k].size() != 0) void'(sq[k].pop_front());
            drv_d = '0; drv_id = '0; drv_rs = '0; drv_l = '0; drv_v = '0;
            for (int k = 0; k < 4; k++) begin
                if (sq[k].size() != 0) begin
                    drv_v[k]          = 1'b1;
                    drv_d[k*32 +: 32] = sq[k][0].data;
                    drv_id[k*4 +: 4]  = sq[k][0].id;
                    drv_rs[k*2 +: 2]  = sq[k][0].resp;
                    drv_l[k]          = sq[k][0].last;
                end
            end
            bus.s_axi_rdata  = drv_d;
            bus.s_axi_rid    = drv_id;
            bus.s_axi_rresp  = drv_rs;
            bus.s_axi_rlast  = drv_l;
            bus.s_axi_rvalid = drv_v;
            #4;
            fired = bus.s_axi_rvalid & bus.s_axi_rready;
            if (bus.m00_axi_rvalid && bus.m00_axi_rready) begin
                got_b = mkb(bus.m00_axi_rdata, bus.m00_axi_rid, bus.m00_axi_rresp, bus.m00_axi_rlast);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_beat", 64'(got_b), 64'(0));
                    if (got_b == '0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_beat: got 0x0 expected none");
                    end
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("sb_beat", 64'(got_b), 64'(exp_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset              = 1'b1;
        bus.m00_axi_rready = 1'b1;
        step(3);
        chk("rst_rvalid", 64'(bus.m00_axi_rvalid), 64'(0));
        chk("rst_rdata",  64'(bus.m00_axi_rdata),  64'(0));
        chk("rst_grant",  64'(bus.r_grant),        64'(0));
        chk("rst_sready", 64'(bus.s_axi_rready),   64'(0));
        reset = 1'b0;

        // 1: single-beat burst from s1
        send(1, mkb(32'hA5A5_0001, 4'h3, 2'b00, 1'b1), 1'b1);
        step(1);
        chk("t1_grant",  64'(bus.r_grant),      64'(4'b0010));
        chk("t1_sready", 64'(bus.s_axi_rready), 64'(4'b0010));
        step(1);
        chk("t1_rvalid", 64'(bus.m00_axi_rvalid), 64'(1));
        chk("t1_rdata",  64'(bus.m00_axi_rdata),  64'(32'hA5A5_0001));
        chk("t1_rid",    64'(bus.m00_axi_rid),    64'(4'h3));
        chk("t1_rlast",  64'(bus.m00_axi_rlast),  64'(1));
        chk("t1_idle",   64'(bus.r_grant),        64'(0));
        drain("t1_drain");

        // 2: 4-beat burst from s2 at full rate, then a 1-beat burst after the bubble
        for (int i = 0; i < 4; i++)
            send(2, mkb(32'h2000_0000 + 32'(i), 4'h2, 2'b00, i == 3), 1'b1);
        send(2, mkb(32'h2000_0010, 4'h2, 2'b01, 1'b1), 1'b1);
        step(1);
        chk("t2_grant", 64'(bus.r_grant), 64'(4'b0100));
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_rvalid", 64'(bus.m00_axi_rvalid), 64'(1));
            chk("t2_rlast",  64'(bus.m00_axi_rlast),  64'(i == 3));
        end
        chk("t2_idle_after_last", 64'(bus.r_grant), 64'(0));
        step(1);
        chk("t2_bubble",  64'(bus.m00_axi_rvalid), 64'(0));
        chk("t2_regrant", 64'(bus.r_grant),        64'(4'b0100));
        step(1);
        chk("t2_next_burst", 64'(bus.m00_axi_rvalid), 64'(1));
        drain("t2_drain");

        // 3: s0 and s3 together from reset; s0 has a second burst queued behind
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        send(0, mkb(32'h0000_00A0, 4'h0, 2'b00, 1'b0), 1'b1);
        send(0, mkb(32'h0000_00A1, 4'h0, 2'b00, 1'b1), 1'b1);
        send(3, mkb(32'h3000_00B0, 4'h3, 2'b00, 1'b0), 1'b1);
        send(3, mkb(32'h3000_00B1, 4'h3, 2'b00, 1'b1), 1'b1);
        // rr_ptr=1 after s0 finishes, so s3 must win over s0's next burst
        exp_q.push_back(mkb(32'h0000_00C0, 4'h1, 2'b00, 1'b1));
        sq[0].push_back(mkb(32'h0000_00C0, 4'h1, 2'b00, 1'b1));
        step(1);
        chk("t3_grant_s0", 64'(bus.r_grant),      64'(4'b0001));
        chk("t3_sready",   64'(bus.s_axi_rready), 64'(4'b0001));
        step(1);
        chk("t3_s3_blocked", 64'(bus.s_axi_rready[3]), 64'(0));
        step(1);
        chk("t3_idle", 64'(bus.r_grant), 64'(0));
        step(1);
        chk("t3_grant_s3", 64'(bus.r_grant), 64'(4'b1000));
        drain("t3_drain");

        // 4: master backpressure for 3 cycles mid-burst
        for (int i = 0; i < 4; i++)
            send(0, mkb(32'h4000_0000 + 32'(i), 4'h5, 2'b00, i == 3), 1'b1);
        step(2);
        chk("t4_rvalid", 64'(bus.m00_axi_rvalid), 64'(1));
        bus.m00_axi_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t4_hold_valid", 64'(bus.m00_axi_rvalid),  64'(1));
            chk("t4_hold_data",  64'(bus.m00_axi_rdata),   64'(32'h4000_0000));
            chk("t4_owner_nrdy", 64'(bus.s_axi_rready[0]), 64'(0));
        end
        bus.m00_axi_rready = 1'b1;
        drain("t4_drain");

        // 5: reset during beat 2 of 4; beat 2 is lost, beat 3 arbitrates afresh
        send(1, mkb(32'h5000_0000, 4'h6, 2'b00, 1'b0), 1'b1);
        send(1, mkb(32'h5000_0001, 4'h6, 2'b00, 1'b0), 1'b1);
        send(1, mkb(32'h5000_0002, 4'h6, 2'b00, 1'b0), 1'b0);
        send(1, mkb(32'h5000_0003, 4'h6, 2'b00, 1'b1), 1'b1);
        step(3);
        reset = 1'b1;
        step(1);
        chk("t5_rvalid", 64'(bus.m00_axi_rvalid), 64'(0));
        chk("t5_rdata",  64'(bus.m00_axi_rdata),  64'(0));
        chk("t5_rid",    64'(bus.m00_axi_rid),    64'(0));
        chk("t5_rlast",  64'(bus.m00_axi_rlast),  64'(0));
        chk("t5_grant",  64'(bus.r_grant),        64'(0));
        chk("t5_sready", 64'(bus.s_axi_rready),   64'(0));
        reset = 1'b0;
        step(1);
        chk("t5_regrant", 64'(bus.r_grant), 64'(4'b0010));
        drain("t5_drain");

        // 6: error response and RID pass through unchanged
        send(3, mkb(32'hE000_0006, 4'hF, 2'b10, 1'b1), 1'b1);
        step(2);
        chk("t6_rresp", 64'(bus.m00_axi_rresp), 64'(2'b10));
        chk("t6_rid",   64'(bus.m00_axi_rid),   64'(4'hF));
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
